iobuf_bank: RTL and testbench

//   Parametrised N-channel controller for the 74LVC1T45-style level-shifting I/O buffers on the Bus Pirate

---
 rtl/iobuf_bank.sv | 171 +++++++++++++++++
 tb/tb_iobuf_bank.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iobuf_bank.sv
// N-channel level-shifter buffer controller: break-before-make direction
// sequencing, open-drain emulation, input synchroniser, sticky contention.
module iobuf_bank #(
  parameter int CHANNELS      = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int CONT_CYCLES   = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] dir,
  input  logic [CHANNELS-1:0] od,
  input  logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] contention,
  input  logic [CHANNELS-1:0] cont_clear,
  output logic                irq,
  output logic [CHANNELS-1:0] bufdir,
  output logic [CHANNELS-1:0] bufod,
  output logic [CHANNELS-1:0] pin_oe,
  output logic [CHANNELS-1:0] pin_out,
  input  logic [CHANNELS-1:0] pin_in
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = $clog2(CONT_CYCLES + 1);
  localparam int BW = $clog2(SYNC_STAGES + 1);

  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] S_ONE     = SW'(1);
  localparam logic [CW-1:0] CONT_MAX  = CW'(CONT_CYCLES);
  localparam logic [CW-1:0] CONT_PRE  = CW'(CONT_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [BW-1:0] BLANK_LD  = BW'(SYNC_STAGES);
  localparam logic [BW-1:0] B_ONE     = BW'(1);

  typedef enum logic [1:0] {
    S_INPUT,
    S_SETTLE_OUT,
    S_OUTPUT,
    S_SETTLE_IN
  } state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t                 state, state_n;
    logic [SW-1:0]          scnt, scnt_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          mcnt, mcnt_n;
    logic [BW-1:0]          blank, blank_n;
    logic                   dout_q, od_q;
    logic                   din_s, chg, blanked, mism, inc;
    logic                   cont_q, cont_set;
    logic                   bufdir_q, bufod_q, pin_oe_q;
    logic                   pin_out_q, busy_q;

    always_comb begin
      state_n = state;
      scnt_n  = scnt;
      unique case (state)
        S_INPUT: begin
          if (dir[g]) begin
            state_n = S_SETTLE_OUT;
            scnt_n  = SETTLE_LD;
          end
        end
        S_SETTLE_OUT: begin
          if (!dir[g]) begin
            state_n = S_INPUT;
            scnt_n  = '0;
          end else if (scnt <= S_ONE) begin
            state_n = S_OUTPUT;
            scnt_n  = '0;
          end else begin
            scnt_n = scnt - S_ONE;
          end
        end
        S_OUTPUT: begin
          if (!dir[g]) begin
            state_n = S_SETTLE_IN;
            scnt_n  = SETTLE_LD;
          end
        end
        S_SETTLE_IN: begin
          if (scnt <= S_ONE) begin
            state_n = S_INPUT;
            scnt_n  = '0;
          end else begin
            scnt_n = scnt - S_ONE;
          end
        end
        default: begin
          state_n = S_INPUT;
          scnt_n  = '0;
        end
      endcase
    end

    // Mismatches are ignored while a dout/od change is still in flight
    // through the synchroniser.
    always_comb begin
      din_s   = sync_q[SYNC_STAGES-1];
      chg     = dout[g] != dout_q;
      blanked = chg || (blank != '0) || (od[g] != od_q);
      mism    = od[g] ? (!dout[g] && din_s)
                      : (din_s != dout[g]);
      inc     = (state == S_OUTPUT) && !blanked && mism;
      if (chg)
        blank_n = BLANK_LD;
      else if (blank != '0)
        blank_n = blank - B_ONE;
      else
        blank_n = '0;
      cont_set = inc && (mcnt == CONT_PRE);
      mcnt_n   = '0;
      if (inc)
        mcnt_n = (mcnt == CONT_MAX) ? mcnt : mcnt + C_ONE;
      if (cont_clear[g] && !cont_set)
        mcnt_n = '0;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state     <= S_INPUT;
        scnt      <= '0;
        sync_q    <= '0;
        mcnt      <= '0;
        blank     <= '0;
        dout_q    <= 1'b0;
        od_q      <= 1'b0;
        cont_q    <= 1'b0;
        bufdir_q  <= 1'b0;
        bufod_q   <= 1'b0;
        pin_oe_q  <= 1'b0;
        pin_out_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        state     <= state_n;
        scnt      <= scnt_n;
        sync_q    <= {sync_q[SYNC_STAGES-2:0], pin_in[g]};
        mcnt      <= mcnt_n;
        blank     <= blank_n;
        dout_q    <= dout[g];
        od_q      <= od[g];
        cont_q    <= cont_set | (cont_q & ~cont_clear[g]);
        bufdir_q  <= state_n != S_INPUT;
        pin_oe_q  <= state_n == S_OUTPUT;
        busy_q    <= (state_n == S_SETTLE_OUT)
                  || (state_n == S_SETTLE_IN);
        pin_out_q <= (state_n == S_OUTPUT) && !od[g] && dout[g];
        bufod_q   <= (state_n == S_OUTPUT) && od[g] && dout[g];
      end
    end

    assign din[g]        = sync_q[SYNC_STAGES-1];
    assign contention[g] = cont_q;
    assign bufdir[g]     = bufdir_q;
    assign bufod[g]      = bufod_q;
    assign pin_oe[g]     = pin_oe_q;
    assign pin_out[g]    = pin_out_q;
    assign busy[g]       = busy_q;
  end

  always_ff @(posedge clock) begin
    if (reset)
      irq <= 1'b0;
    else
      irq <= |contention;
  end

endmodule

// File: tb/tb_iobuf_bank.sv
// Scoreboard bench for iobuf_bank: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_iobuf_bank;
  localparam int CH = 5;
  localparam int S_BUFDIR = 0;
  localparam int S_PINOE  = 1;
  localparam int S_BUSY   = 2;
  localparam int S_CONT   = 3;
  localparam int S_IRQ    = 4;
  localparam int S_BUFOD  = 5;
  localparam int S_PINOUT = 6;
  localparam int S_DIN    = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [CH-1:0] dir0 = '0, od0 = '0, dout0 = '0;
  logic [CH-1:0] clr0 = '0, pin_in0 = '0;
  logic [CH-1:0] din0, busy0, cont0, bufdir0, bufod0;
  logic [CH-1:0] pin_oe0, pin_out0;
  logic          irq0;

  logic [CH-1:0] dir1 = '0, od1 = '0, dout1 = '0;
  logic [CH-1:0] clr1 = '0, pin_in1 = '0;
  logic [CH-1:0] din1, busy1, cont1, bufdir1, bufod1;
  logic [CH-1:0] pin_oe1, pin_out1;
  logic          irq1;

  iobuf_bank #(
    .CHANNELS(CH), .SETTLE_CYCLES(4),
    .CONT_CYCLES(8), .SYNC_STAGES(2)
  ) u_dut0 (
    .clock(clk), .reset(rst),
    .dir(dir0), .od(od0), .dout(dout0),
    .din(din0), .busy(busy0), .contention(cont0),
    .cont_clear(clr0), .irq(irq0),
    .bufdir(bufdir0), .bufod(bufod0),
    .pin_oe(pin_oe0), .pin_out(pin_out0),
    .pin_in(pin_in0)
  );

  iobuf_bank #(
    .CHANNELS(CH), .SETTLE_CYCLES(1),
    .CONT_CYCLES(8), .SYNC_STAGES(3)
  ) u_dut1 (
    .clock(clk), .reset(rst),
    .dir(dir1), .od(od1), .dout(dout1),
    .din(din1), .busy(busy1), .contention(cont1),
    .cont_clear(clr1), .irq(irq1),
    .bufdir(bufdir1), .bufod(bufod1),
    .pin_oe(pin_oe1), .pin_out(pin_out1),
    .pin_in(pin_in1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int d;
    int s;
    int ch;
    bit v;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic string sname(int s);
    case (s)
      S_BUFDIR: return "bufdir";
      S_PINOE:  return "pin_oe";
      S_BUSY:   return "busy";
      S_CONT:   return "contention";
      S_IRQ:    return "irq";
      S_BUFOD:  return "bufod";
      S_PINOUT: return "pin_out";
      default:  return "din";
    endcase
  endfunction

  function automatic bit samp(int d, int s, int ch);
    logic [CH-1:0] v;
    case (s)
      S_BUFDIR: v = d ? bufdir1 : bufdir0;
      S_PINOE:  v = d ? pin_oe1 : pin_oe0;
      S_BUSY:   v = d ? busy1 : busy0;
      S_CONT:   v = d ? cont1 : cont0;
      S_IRQ:    v = {{(CH-1){1'b0}}, d ? irq1 : irq0};
      S_BUFOD:  v = d ? bufod1 : bufod0;
      S_PINOUT: v = d ? pin_out1 : pin_out0;
      default:  v = d ? din1 : din0;
    endcase
    return v[ch];
  endfunction

  task automatic ex(int off, int d, int s, int ch, bit v);
    exp_t e;
    e.cyc = cyc + off;
    e.d   = d;
    e.s   = s;
    e.ch  = ch;
    e.v   = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        bit a;
        a = samp(sb[i].d, sb[i].s, sb[i].ch);
        n_cmp++;
        if (sb[i].cyc < cyc || a !== sb[i].v) begin
          n_bad++;
          $display("FAIL %s dut%0d ch%0d cyc %0d: got %0b want %0b",
                   sname(sb[i].s), sb[i].d, sb[i].ch,
                   sb[i].cyc, a, sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] hist;
    int guard;
    tick(2);
    for (int c = 0; c < CH; c++) begin
      ex(0, 0, S_BUFDIR, c, 1'b0);
      ex(0, 0, S_PINOE, c, 1'b0);
      ex(0, 0, S_BUSY, c, 1'b0);
      ex(0, 0, S_CONT, c, 1'b0);
      ex(0, 0, S_BUFOD, c, 1'b0);
      ex(0, 0, S_PINOUT, c, 1'b0);
      ex(0, 0, S_DIN, c, 1'b0);
      ex(0, 1, S_BUFDIR, c, 1'b0);
    end
    ex(0, 0, S_IRQ, 0, 1'b0);
    rst = 1'b0;

    // three-stage synchroniser latency on the second bank
    pin_in1[2] = 1'b1;
    ex(2, 1, S_DIN, 2, 1'b0);
    ex(3, 1, S_DIN, 2, 1'b1);

    // direction sequencing on channel 0
    dir0[0] = 1'b1;
    dout0[0] = 1'b1;
    pin_in0[0] = 1'b1;
    ex(0, 0, S_BUFDIR, 0, 1'b0);
    ex(1, 0, S_BUFDIR, 0, 1'b1);
    ex(4, 0, S_PINOE, 0, 1'b0);
    ex(5, 0, S_PINOE, 0, 1'b1);
    for (int k = 1; k <= 4; k++) ex(k, 0, S_BUSY, 0, 1'b1);
    ex(5, 0, S_BUSY, 0, 1'b0);
    ex(1, 0, S_DIN, 0, 1'b0);
    ex(2, 0, S_DIN, 0, 1'b1);
    ex(5, 0, S_PINOUT, 0, 1'b1);
    ex(5, 0, S_BUFOD, 0, 1'b0);
    for (int c = 1; c < CH; c++) ex(5, 0, S_BUFDIR, c, 1'b0);
    tick(8);

    // push-pull contention, clear under persistent mismatch, re-set
    pin_in0[0] = 1'b0;
    ex(9, 0, S_CONT, 0, 1'b0);
    ex(10, 0, S_CONT, 0, 1'b1);
    ex(10, 0, S_IRQ, 0, 1'b0);
    ex(11, 0, S_IRQ, 0, 1'b1);
    tick(12);
    clr0[0] = 1'b1;
    ex(1, 0, S_CONT, 0, 1'b0);
    ex(1, 0, S_IRQ, 0, 1'b1);
    ex(2, 0, S_IRQ, 0, 1'b0);
    ex(8, 0, S_CONT, 0, 1'b0);
    ex(9, 0, S_CONT, 0, 1'b1);
    ex(10, 0, S_IRQ, 0, 1'b1);
    tick(1);
    clr0[0] = 1'b0;
    tick(11);
    pin_in0[0] = 1'b1;
    clr0[0] = 1'b1;
    ex(1, 0, S_CONT, 0, 1'b0);
    ex(3, 0, S_IRQ, 0, 1'b0);
    ex(4, 0, S_CONT, 0, 1'b0);
    tick(1);
    clr0[0] = 1'b0;
    tick(5);

    // open-drain: released 1 held low externally is fine
    od0[0] = 1'b1;
    pin_in0[0] = 1'b0;
    ex(1, 0, S_BUFOD, 0, 1'b1);
    ex(1, 0, S_PINOUT, 0, 1'b0);
    ex(1, 0, S_PINOE, 0, 1'b1);
    ex(12, 0, S_CONT, 0, 1'b0);
    ex(12, 0, S_BUFOD, 0, 1'b1);
    tick(12);
    // open-drain driving 0 while pin reads 1
    dout0[0] = 1'b0;
    pin_in0[0] = 1'b1;
    ex(1, 0, S_BUFOD, 0, 1'b0);
    ex(1, 0, S_PINOUT, 0, 1'b0);
    ex(10, 0, S_CONT, 0, 1'b0);
    ex(11, 0, S_CONT, 0, 1'b1);
    ex(11, 0, S_IRQ, 0, 1'b0);
    ex(12, 0, S_IRQ, 0, 1'b1);
    tick(13);
    clr0[0] = 1'b1;
    pin_in0[0] = 1'b0;
    od0[0] = 1'b0;
    ex(1, 0, S_CONT, 0, 1'b0);
    ex(2, 0, S_IRQ, 0, 1'b0);
    ex(6, 0, S_CONT, 0, 1'b0);
    tick(1);
    clr0[0] = 1'b0;
    tick(6);

    // output -> input break-before-make
    dir0[0] = 1'b0;
    ex(0, 0, S_PINOE, 0, 1'b1);
    ex(1, 0, S_PINOE, 0, 1'b0);
    ex(1, 0, S_BUFDIR, 0, 1'b1);
    ex(4, 0, S_BUFDIR, 0, 1'b1);
    ex(5, 0, S_BUFDIR, 0, 1'b0);
    ex(1, 0, S_BUSY, 0, 1'b1);
    ex(4, 0, S_BUSY, 0, 1'b1);
    ex(5, 0, S_BUSY, 0, 1'b0);
    tick(7);

    // abort during settle-out: pin_oe never rises
    dir0[0] = 1'b1;
    for (int k = 1; k <= 8; k++) ex(k, 0, S_PINOE, 0, 1'b0);
    ex(2, 0, S_BUFDIR, 0, 1'b1);
    ex(3, 0, S_BUFDIR, 0, 1'b0);
    ex(2, 0, S_BUSY, 0, 1'b1);
    ex(3, 0, S_BUSY, 0, 1'b0);
    tick(2);
    dir0[0] = 1'b0;
    tick(7);

    // fast dout toggling with lagging pin: blanking hides it
    dir0[1] = 1'b1;
    dout0[1] = 1'b0;
    pin_in0[1] = 1'b0;
    tick(6);
    ex(0, 0, S_PINOE, 1, 1'b1);
    hist = 2'b00;
    for (int i = 0; i < 22; i++) begin
      if (i < 20) dout0[1] = ~dout0[1];
      pin_in0[1] = hist[1];
      hist = {hist[0], dout0[1]};
      ex(1, 0, S_CONT, 1, 1'b0);
      tick(1);
    end
    ex(10, 0, S_CONT, 1, 1'b0);
    ex(10, 0, S_IRQ, 0, 1'b0);
    tick(10);

    // reset in the middle of settle-in
    dir0[1] = 1'b0;
    pin_in0[1] = 1'b1;
    tick(2);
    ex(0, 0, S_BUSY, 1, 1'b1);
    ex(0, 0, S_BUFDIR, 1, 1'b1);
    ex(0, 0, S_DIN, 1, 1'b1);
    rst = 1'b1;
    ex(1, 0, S_BUSY, 1, 1'b0);
    ex(1, 0, S_BUFDIR, 1, 1'b0);
    ex(1, 0, S_PINOE, 1, 1'b0);
    ex(1, 0, S_DIN, 1, 1'b0);
    ex(1, 0, S_CONT, 1, 1'b0);
    ex(1, 0, S_IRQ, 0, 1'b0);
    tick(1);
    rst = 1'b0;
    pin_in0 = '0;
    pin_in1 = '0;
    dout0 = '0;
    od0 = '0;
    tick(2);

    // staggered requests on every channel of both banks
    for (int k = 0; k < CH; k++) begin
      ex(k, 0, S_BUFDIR, k, 1'b0);
      ex(k + 1, 0, S_BUFDIR, k, 1'b1);
      ex(k + 4, 0, S_PINOE, k, 1'b0);
      ex(k + 5, 0, S_PINOE, k, 1'b1);
      ex(k + 1, 0, S_BUSY, k, 1'b1);
      ex(k + 5, 0, S_BUSY, k, 1'b0);
      ex(k + 1, 1, S_BUFDIR, k, 1'b1);
      ex(k + 1, 1, S_PINOE, k, 1'b0);
      ex(k + 2, 1, S_PINOE, k, 1'b1);
      ex(k + 1, 1, S_BUSY, k, 1'b1);
      ex(k + 2, 1, S_BUSY, k, 1'b0);
    end
    for (int k = 0; k < CH; k++) begin
      dir0[k] = 1'b1;
      dir1[k] = 1'b1;
      tick(1);
    end
    tick(12);
    for (int k = 0; k < CH; k++) begin
      ex(0, 0, S_CONT, k, 1'b0);
      ex(0, 1, S_CONT, k, 1'b0);
    end
    ex(0, 0, S_IRQ, 0, 1'b0);
    ex(0, 1, S_IRQ, 0, 1'b0);

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      tick(1);
      guard++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
